// File: rtl/lp_filter_scheduler_if.sv
// rtl/lp_filter_scheduler_if.sv - sample/result bus of the shared-datapath IIR scheduler
interface lp_filter_scheduler_if #(
    parameter int NCH       = 4,
    parameter int DATA_BITS = 28
);
    localparam int CW = $clog2(NCH);

    logic                     ce_i;
    logic [NCH-1:0]           in_valid_i;
    logic [NCH*DATA_BITS-1:0] in_value_i;
    logic                     out_valid_o;
    logic [DATA_BITS-1:0]     out_value_o;
    logic [CW-1:0]            out_channel_o;
    logic [NCH-1:0]           overrun_o;

    modport master (
        output ce_i, in_valid_i, in_value_i,
        input  out_valid_o, out_value_o, out_channel_o, overrun_o
    );

    modport slave (
        input  ce_i, in_valid_i, in_value_i,
        output out_valid_o, out_value_o, out_channel_o, overrun_o
    );
endinterface

// File: rtl/lp_filter_scheduler.sv
// rtl/lp_filter_scheduler.sv - round-robin scheduler of NCH channels over one cascaded IIR stage
module lp_filter_scheduler #(
    parameter int NCH         = 4,
    parameter int DATA_BITS   = 28,
    parameter int SHIFT_BITS  = 6,
    parameter int STAGE_COUNT = 4
) (
    input logic                   clk_i,
    input logic                   rst_i,
    lp_filter_scheduler_if.slave  bus
);
    localparam int CW = $clog2(NCH);
    localparam int KW = (STAGE_COUNT > 1) ? $clog2(STAGE_COUNT) : 1;

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t                 fsm_q;
    logic [KW-1:0]        k_q;
    logic [CW-1:0]        ch_q;
    logic [CW-1:0]        ptr_q;
    logic [DATA_BITS-1:0] x_q;
    logic                 prime_q;
    logic [NCH-1:0]       pending_q;
    logic [NCH-1:0]       primed_q;
    logic [NCH-1:0]       overrun_q;
    logic                 out_valid_q;
    logic [DATA_BITS-1:0] out_value_q;
    logic [CW-1:0]        out_channel_q;
    logic [DATA_BITS-1:0] sample_q [NCH];
    logic [DATA_BITS-1:0] state_q  [NCH][STAGE_COUNT];

    logic                 grant_found;
    logic                 grant_en;
    logic [CW-1:0]        grant_ch;
    logic [CW-1:0]        next_ptr;
    int                   j;

    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        j           = 0;
        for (int i = 0; i < NCH; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NCH) j = j - NCH;
            if (!grant_found && pending_q[j]) begin
                grant_found = 1'b1;
                grant_ch    = CW'(j);
            end
        end
        grant_en = bus.ce_i && (fsm_q == IDLE) && grant_found;
        next_ptr = (grant_ch == CW'(NCH - 1)) ? '0 : grant_ch + 1'b1;
    end

    // Difference carries one extra bit so the floor shift sees the true sign.
    logic [DATA_BITS-1:0]        s_cur;
    logic [DATA_BITS-1:0]        s_new;
    logic signed [DATA_BITS:0]   diff;
    logic signed [DATA_BITS:0]   delta;

    always_comb begin
        s_cur = state_q[ch_q][k_q];
        diff  = $signed({1'b0, x_q}) - $signed({1'b0, s_cur});
        delta = diff >>> SHIFT_BITS;
        s_new = prime_q ? x_q : s_cur + DATA_BITS'(delta);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q         <= IDLE;
            k_q           <= '0;
            ch_q          <= '0;
            ptr_q         <= '0;
            x_q           <= '0;
            prime_q       <= 1'b0;
            pending_q     <= '0;
            primed_q      <= '0;
            overrun_q     <= '0;
            out_valid_q   <= 1'b0;
            out_value_q   <= '0;
            out_channel_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                sample_q[c] <= '0;
                for (int s = 0; s < STAGE_COUNT; s++) state_q[c][s] <= '0;
            end
        end else begin
            overrun_q <= '0;
            if (grant_en) pending_q[grant_ch] <= 1'b0;
            // A strobe on the channel being granted re-arms it; the grant takes the older sample.
            for (int c = 0; c < NCH; c++) begin
                if (bus.in_valid_i[c]) begin
                    sample_q[c]  <= bus.in_value_i[c*DATA_BITS +: DATA_BITS];
                    pending_q[c] <= 1'b1;
                    overrun_q[c] <= pending_q[c] && !(grant_en && grant_ch == CW'(c));
                end
            end
            if (bus.ce_i) begin
                out_valid_q <= 1'b0;
                case (fsm_q)
                    IDLE: begin
                        if (grant_en) begin
                            fsm_q              <= RUN;
                            k_q                <= '0;
                            ch_q               <= grant_ch;
                            x_q                <= sample_q[grant_ch];
                            prime_q            <= !primed_q[grant_ch];
                            primed_q[grant_ch] <= 1'b1;
                            ptr_q              <= next_ptr;
                        end
                    end
                    RUN: begin
                        state_q[ch_q][k_q] <= s_new;
                        x_q                <= s_new;
                        if (k_q == KW'(STAGE_COUNT - 1)) begin
                            fsm_q         <= IDLE;
                            out_valid_q   <= 1'b1;
                            out_value_q   <= s_new;
                            out_channel_q <= ch_q;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                    default: fsm_q <= IDLE;
                endcase
            end
        end
    end

    // A completed result waits in out_valid_q until a cycle with ce_i high.
    assign bus.out_valid_o   = out_valid_q & bus.ce_i;
    assign bus.out_value_o   = out_value_q;
    assign bus.out_channel_o = out_channel_q;
    assign bus.overrun_o     = overrun_q;
endmodule

// File: doc/lp_filter_scheduler.md
LP_FILTER_SCHEDULER -- requirements
Module: lp_filter_scheduler

Parameters
REQ-001 SHALL declare parameters, one per line, as follows:
- NCH, default 4, number of input channels sharing one filter datapath (2..8).
- DATA_BITS, default 28, width of each sample and filter state.
- SHIFT_BITS, default 6, IIR coefficient exponent: alpha = 2^-SHIFT_BITS.
- STAGE_COUNT, default 4, cascaded IIR stages per channel (1..5).

Interface
REQ-002 SHALL have one clock; reset is asynchronous and active-high. Ports are listed below as name, direction, width, meaning.
- CLK  in  1  single clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CE  in  1  sequencer enable; 0 pauses sequencing.
- IN_VALID  in  NCH  per-channel new-sample strobe, one cycle.
- IN_VALUE  in  NCH*DATA_BITS  channel c sample at bits [c*DATA_BITS +: DATA_BITS], unsigned.
- OUT_VALID  out  1  one-cycle pulse: OUT_VALUE/OUT_CHANNEL valid.
- OUT_VALUE  out  DATA_BITS  final-stage filtered value of OUT_CHANNEL.
- OUT_CHANNEL  out  clog2(NCH)  channel index of current result.
- OVERRUN  out  NCH  one-cycle pulse per channel: unprocessed pending sample overwritten.

Function
REQ-003 SHALL time-multiplex one shared stage datapath over all channels; per-channel, per-stage state held in an NCH x STAGE_COUNT register array.
REQ-004 Stage update SHALL be: s_new = s + ((x - s) >>> SHIFT_BITS), where x - s is computed signed on DATA_BITS+1 bits with an arithmetic (floor) shift, the result is truncated to DATA_BITS, x is the stage input, and stage k input is stage k-1 new value (stage 0 input = latched sample).
REQ-005 Input capture SHALL be independent of CE: IN_VALID[c]=1 latches IN_VALUE slice c and sets pending[c].
REQ-006 If pending[c] is already set on a new IN_VALID[c], the sample SHALL be overwritten (latest wins) and OVERRUN[c] SHALL pulse next cycle.
REQ-007 If IN_VALID[c] coincides with grant of channel c, the granted sample SHALL be the one already latched; the new sample is latched and pending[c] remains set; no OVERRUN.
REQ-008 The FSM SHALL have states IDLE and RUN.
- IDLE: if CE and any pending, grant round-robin (search starts at last granted+1, wrapping NCH-1 to 0), copy sample to working register, clear pending, set k=0, go to RUN.
- RUN: one stage per CE cycle; write back state[ch][k]; k increments; after k=STAGE_COUNT-1, go to IDLE.
REQ-009 OUT_VALID SHALL pulse in the cycle after the last stage's write, with OUT_VALUE = new state[ch][STAGE_COUNT-1] and OUT_CHANNEL = ch; OUT_VALUE/OUT_CHANNEL hold until the next pulse.
REQ-010 Latency: IN_VALID sampled at edge N to an idle scheduler -> OUT_VALID high during cycle N+STAGE_COUNT+2.
REQ-011 Throughput: one channel per STAGE_COUNT+1 CE cycles. The grant in IDLE MAY coincide with the previous OUT_VALID pulse.
REQ-012 CE=0 SHALL freeze FSM, k, state array and round-robin pointer; OUT_VALID SHALL be 0 while CE=0, and a due pulse is issued on the first cycle CE returns to 1.
REQ-013 Priming: primed[c] SHALL be cleared by reset; the first processed sample of channel c writes that sample into all stages of c, outputs it unchanged, and sets primed[c].

Reset
REQ-014 RESET=1 SHALL asynchronously force:
- FSM to IDLE, k=0.
- pending, primed, OVERRUN, OUT_VALID to 0.
- OUT_VALUE, OUT_CHANNEL, state array, round-robin pointer to 0 (first search starts at channel 0).
REQ-015 Reset mid-RUN SHALL abandon the in-flight channel with no OUT_VALID.
REQ-016 After reset deassertion, processing SHALL resume from IDLE on the next edge.

Verification (NCH=4, DATA_BITS=28, SHIFT_BITS=6, STAGE_COUNT=4, CE=1 unless stated)
REQ-017 Prime: ch0 sample 1000 at edge N -> OUT_VALID in cycle N+6, OUT_VALUE=1000, OUT_CHANNEL=0.
REQ-018 Step up: primed ch0=1000, sample 7400 -> stage values 1100, 1001, 1000, 1000; OUT_VALUE=1000.
REQ-019 Step down/floor: primed ch1=64, sample 0 -> every stage 63; OUT_VALUE=63.
REQ-020 Arbitration: IN_VALID=4'b1111 in one cycle from reset -> results ordered ch0, ch1, ch2, ch3, OUT_VALID spaced 5 cycles apart.
REQ-021 Overrun/CE: ch2 strobed twice while ch0 runs -> OVERRUN[2] pulses once and the second value is processed; CE held 0 for 3 cycles mid-RUN -> OUT_VALID delayed exactly 3 cycles with an identical value.
REQ-022 Reset mid-RUN at k=2 -> no OUT_VALID; all outputs 0; next ch3 sample is treated as a priming sample.
